seg_int: RTL and testbench
==========================

Name: seg_int

Overview:
- Inverse of the team's binary-to-segment display converter. Takes a 32-bit four-digit seven-segment word and returns the 14-bit unsigned integer it shows.
- Used by the calculator to read a displayed or entered value back into the arithmetic path.
- Flow: decode each segment byte to a BCD nibble, then run a 14-iteration reverse double-dabble (shift right, subtract 3 from any nibble >= 8).

Parameters:
- NUM_W, 14, binary result width; also the iteration count.
- N_DIG, 4, number of display digits. Requires 10^N_DIG-1 < 2^NUM_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- digits  input  8*N_DIG  segment word. Digit 0 is in bits 7:0 (least significant); digit 3 is in bits 31:24.
- convert  input  1  start request, sampled only in IDLE.
- num  output  NUM_W  converted value.
- conv_done  output  1  one-cycle completion pulse.
- error  output  1  one-cycle pulse, coincident with conv_done, when the word is not a valid number.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; num=0, conv_done=0, error=0, busy=0; internal shift register cleared.
- Segment codes, bit 7 (dp) must be 0:
  - 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9.
  - Any other code is invalid.
- States IDLE, DECODE, CONV, DONE, ERR:
  - IDLE: if convert=1, latch digits and go to DECODE. Otherwise stay.
  - DECODE (1 cycle): map the latched bytes to nibbles and load the shift register with {BCD[4*N_DIG-1:0], NUM_W'b0}. Any invalid byte goes to ERR; otherwise go to CONV with iteration counter = 0.
  - CONV (NUM_W cycles): each cycle, shift the whole register right by 1, then subtract 3 from every BCD nibble >= 8. The counter increments each cycle. After iteration NUM_W-1, go to DONE.
  - DONE (1 cycle): num = low NUM_W bits of the register; conv_done=1, error=0; next state IDLE.
  - ERR (1 cycle): num=0, conv_done=1, error=1; next state IDLE.
- Latency, with edge 0 being the edge that samples convert:
  - Valid path: conv_done is high during the cycle after edge 16 (1 DECODE + 14 CONV + DONE).
  - Error path: conv_done and error are high during the cycle after edge 2.
- Handshake and holding:
  - convert is ignored while busy=1. No queueing; the requester must wait for conv_done.
  - num holds its value between conversions and changes only in DONE or ERR.
  - convert held high continuously restarts a conversion in the cycle after DONE/ERR (back-to-back allowed).
- Arithmetic:
  - The shift register is 4*N_DIG+NUM_W = 30 bits.
  - Nibble subtraction is modulo 16, but never underflows because it only applies when the nibble is >= 8.
  - The BCD part is all zero at the end of CONV.
- rst_n asserted mid-conversion: abort immediately, return to the reset values; no conv_done.
- digits may change after the sampling edge without affecting the result.

Optional Feature:
- Macro: SEG_BLANK_ZERO_EN.
- Defined: byte 0x00 (blank digit) decodes as 0, so left-blanked displays convert correctly.
- Not defined: 0x00 is invalid and produces error.

Decomposition:
- Shared package calc_pkg, holding:
  - the state enum;
  - the ten segment-code constants;
  - SEG_BLANK = 8'h00;
  - ERR_WORD = 32'h763D507C (the error display pattern, for testbench use).
- One natural sub-module, seg_bcd_dec: a combinational byte-to-{valid, nibble} decoder, instantiated N_DIG times inside seg_int.

Test Plan:
- 0x065B4F66 ("1234") with convert pulse -> conv_done after 16 edges; num=1234 (0x04D2); error=0.
- 0x6F6F6F6F ("9999") -> num=9999 (0x270F). Then 0x3F3F3F3F ("0000") back-to-back -> num=0; second conv_done 17 cycles after the first.
- 0x763D507C (error word) -> conv_done+error at edge 2; num=0; busy low in the following cycle.
- 0x0000066D ("  15"): with SEG_BLANK_ZERO_EN -> num=15, error=0; without -> error=1, num=0.
- Start 0x065B4F66, assert rst_n=0 at edge 8 -> num=0, busy=0, no conv_done pulse. After release, a new convert gives num=1234.
- Convert re-pulsed at edges 3 and 10 during a busy 0x6D6D6D6D ("5555") conversion -> ignored; exactly one conv_done; num=5555.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator types and constants: FSM states, seven-segment codes,
// blank/error display patterns and the reverse double-dabble nibble adjust.
package calc_pkg;

  localparam int DEF_NUM_W = 14;
  localparam int DEF_N_DIG = 4;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    CONV,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;

  localparam logic [7:0]  SEG_BLANK = 8'h00;
  localparam logic [31:0] ERR_WORD  = 32'h763D507C;

  // Nibbles >= 8 after a right shift came from an odd upper digit; undo the +3 of double-dabble.
  function automatic logic [3:0] nib_adjust(input logic [3:0] n);
    return (n >= 4'd8) ? (n - 4'd3) : n;
  endfunction

endpackage

// File: rtl/seg_int_if.sv
// Request/result bundle between a requester (master) and the seg_int converter (slave).
interface seg_int_if
  import calc_pkg::*;
#(
  parameter int NUM_W = DEF_NUM_W,
  parameter int N_DIG = DEF_N_DIG
) ();

  logic [8*N_DIG-1:0] digits;
  logic               convert;
  logic [NUM_W-1:0]   num;
  logic               conv_done;
  logic               error;
  logic               busy;

  modport master (
    output digits, convert,
    input  num, conv_done, error, busy
  );

  modport slave (
    input  digits, convert,
    output num, conv_done, error, busy
  );

endinterface

// File: rtl/seg_bcd_dec.sv
// Combinational seven-segment byte to {valid, BCD nibble} decoder.
// Define SEG_BLANK_ZERO_EN to accept the blank byte 0x00 as digit 0.
module seg_bcd_dec
  import calc_pkg::*;
(
  input  logic [7:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b1;
    nibble = 4'd0;
    case (seg)
      SEG_0: nibble = 4'd0;
      SEG_1: nibble = 4'd1;
      SEG_2: nibble = 4'd2;
      SEG_3: nibble = 4'd3;
      SEG_4: nibble = 4'd4;
      SEG_5: nibble = 4'd5;
      SEG_6: nibble = 4'd6;
      SEG_7: nibble = 4'd7;
      SEG_8: nibble = 4'd8;
      SEG_9: nibble = 4'd9;
`ifdef SEG_BLANK_ZERO_EN
      SEG_BLANK: nibble = 4'd0;
`endif
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_int.sv
// Seven-segment word to unsigned integer converter using reverse double-dabble.
// Blank-digit handling follows SEG_BLANK_ZERO_EN inside seg_bcd_dec.
module seg_int
  import calc_pkg::*;
#(
  parameter int NUM_W = DEF_NUM_W,
  parameter int N_DIG = DEF_N_DIG
) (
  input logic  clk,
  input logic  rst_n,
  seg_int_if.slave bus
);

  localparam int SR_W  = 4*N_DIG + NUM_W;
  localparam int CNT_W = $clog2(NUM_W);

  state_t             state_q, state_d;
  logic [8*N_DIG-1:0] digits_q, digits_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic               conv_done_q, conv_done_d;
  logic               error_q, error_d;
  logic               busy_q, busy_d;

  logic [N_DIG-1:0]   dig_valid;
  logic [4*N_DIG-1:0] bcd;
  logic [SR_W-1:0]    sr_step;

  for (genvar g = 0; g < N_DIG; g++) begin : g_dec
    seg_bcd_dec u_dec (
      .seg    (digits_q[8*g +: 8]),
      .valid  (dig_valid[g]),
      .nibble (bcd[4*g +: 4])
    );
  end

  // One reverse double-dabble iteration over the whole register.
  always_comb begin
    sr_step = sr_q >> 1;
    for (int i = 0; i < N_DIG; i++) begin
      sr_step[NUM_W + 4*i +: 4] = nib_adjust(sr_step[NUM_W + 4*i +: 4]);
    end
  end

  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    conv_done_d = 1'b0;
    error_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.convert) begin
          digits_d = bus.digits;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        sr_d    = {bcd, {NUM_W{1'b0}}};
        cnt_d   = '0;
        state_d = (&dig_valid) ? CONV : ERR;
      end
      CONV: begin
        sr_d  = sr_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NUM_W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        num_d       = sr_q[NUM_W-1:0];
        conv_done_d = 1'b1;
        state_d     = IDLE;
      end
      ERR: begin
        num_d       = '0;
        conv_done_d = 1'b1;
        error_d     = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      digits_q    <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      num_q       <= '0;
      conv_done_q <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      conv_done_q <= conv_done_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.num       = num_q;
  assign bus.conv_done = conv_done_q;
  assign bus.error     = error_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_seg_int.sv
// Self-checking bench for seg_int; result scoreboard plus per-scenario latency checks.
module tb_seg_int;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seg_int_if #(.NUM_W(14), .N_DIG(4)) bus ();

  seg_int #(.NUM_W(14), .N_DIG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [13:0] num;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Scoreboard: every completion pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.conv_done === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: got pulse num=%0d error=%0b, required no pulse", bus.num, bus.error);
      end else begin
        e = sb.pop_front();
        compared++;
        if (bus.num !== e.num) begin
          mismatched++;
          $display("[TB] FAIL sb_num: got %0d, required %0d", bus.num, e.num);
        end
        compared++;
        if (bus.error !== e.err) begin
          mismatched++;
          $display("[TB] FAIL sb_error: got %0b, required %0b", bus.error, e.err);
        end
      end
    end
  end

  // Drive a request so that the next rising edge (edge 0) samples it.
  task automatic start(input logic [31:0] w, input logic [13:0] n, input logic e, input logic hold);
    @(negedge clk);
    bus.digits  = w;
    bus.convert = 1'b1;
    sb.push_back('{num: n, err: e});
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.convert = 1'b0;
      bus.digits  = 32'hFFFF_FFFF;
    end
  endtask

  // Returns the cycle index (0 = cycle after edge 0) of the completion pulse, or -1.
  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.conv_done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.digits  = '0;
    bus.convert = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if (bus.num !== 14'd0) begin mismatched++; $display("[TB] FAIL reset_num: got %0d, required 0", bus.num); end
    compared++;
    if (bus.conv_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b, required 0", bus.conv_done); end
    compared++;
    if (bus.error !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_error: got %b, required 0", bus.error); end
    compared++;
    if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b, required 0", bus.busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    start(32'h065B4F66, 14'd1234, 1'b0, 1'b0);
    wait_done(40, n);
    compared++;
    if (n != 16) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d, required 16", n); end
    compared++;
    if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_busy_at_done: got %b, required 0", bus.busy); end
    repeat (5) @(negedge clk);
    compared++;
    if (bus.num !== 14'd1234) begin mismatched++; $display("[TB] FAIL basic_hold: got %0d, required 1234", bus.num); end
  endtask

  task automatic test_back_to_back();
    int n1;
    int gap;
    start(32'h6F6F6F6F, 14'd9999, 1'b0, 1'b1);
    wait_done(40, n1);
    compared++;
    if (n1 != 16) begin mismatched++; $display("[TB] FAIL b2b_first_latency: got %0d, required 16", n1); end
    bus.digits = 32'h3F3F3F3F;
    sb.push_back('{num: 14'd0, err: 1'b0});
    gap = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) bus.convert = 1'b0;
      if (bus.conv_done === 1'b1) begin
        gap = i + 1;
        break;
      end
    end
    compared++;
    if (gap != 17) begin mismatched++; $display("[TB] FAIL b2b_gap: got %0d, required 17", gap); end
    compared++;
    if (bus.num !== 14'd0) begin mismatched++; $display("[TB] FAIL b2b_second_num: got %0d, required 0", bus.num); end
  endtask

  task automatic test_error();
    int n;
    start(ERR_WORD, 14'd0, 1'b1, 1'b0);
    wait_done(10, n);
    compared++;
    if (n != 2) begin mismatched++; $display("[TB] FAIL err_latency: got %0d, required 2", n); end
    @(negedge clk);
    compared++;
    if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL err_busy_after: got %b, required 0", bus.busy); end
    compared++;
    if (bus.error !== 1'b0) begin mismatched++; $display("[TB] FAIL err_pulse_width: got %b, required 0", bus.error); end
  endtask

  task automatic test_blank();
    int n;
    int want_lat;
`ifdef SEG_BLANK_ZERO_EN
    want_lat = 16;
    start(32'h0000066D, 14'd15, 1'b0, 1'b0);
`else
    want_lat = 2;
    start(32'h0000066D, 14'd0, 1'b1, 1'b0);
`endif
    wait_done(40, n);
    compared++;
    if (n != want_lat) begin mismatched++; $display("[TB] FAIL blank_latency: got %0d, required %0d", n, want_lat); end
  endtask

  task automatic test_ignore_convert();
    int n;
    int pulses;
    n      = -1;
    pulses = 0;
    start(32'h6D6D6D6D, 14'd5555, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.conv_done === 1'b1) begin
        pulses++;
        if (n < 0) n = i;
      end
      bus.convert = (i == 2 || i == 9);
    end
    bus.convert = 1'b0;
    compared++;
    if (pulses != 1) begin mismatched++; $display("[TB] FAIL ignore_pulses: got %0d, required 1", pulses); end
    compared++;
    if (n != 16) begin mismatched++; $display("[TB] FAIL ignore_latency: got %0d, required 16", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses;
    pulses = 0;
    start(32'h065B4F66, 14'd1234, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    sb.delete();
    compared++;
    if (bus.num !== 14'd0) begin mismatched++; $display("[TB] FAIL mid_reset_num: got %0d, required 0", bus.num); end
    compared++;
    if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_busy: got %b, required 0", bus.busy); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      if (bus.conv_done === 1'b1) pulses++;
    end
    compared++;
    if (pulses != 0) begin mismatched++; $display("[TB] FAIL mid_reset_no_done: got %0d pulses, required 0", pulses); end
    start(32'h065B4F66, 14'd1234, 1'b0, 1'b0);
    wait_done(40, n);
    compared++;
    if (n != 16) begin mismatched++; $display("[TB] FAIL mid_reset_restart_latency: got %0d, required 16", n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_error();
    test_blank();
    test_ignore_convert();
    test_reset_mid();
    repeat (3) @(negedge clk);
    compared++;
    if (sb.size() != 0) begin mismatched++; $display("[TB] FAIL sb_leftover: got %0d outstanding, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
